fir_seq_mac: RTL and testbench

Sequential single-MAC FIR filter that consumes the 24-bit signed sample stream from the test-signal generators, such as the 50 Hz sine source. It is the first filtering stage ahead of the adaptive-filter blocks. Each accepted sample goes into a circular delay line. One multiply-accumulate per clock runs over all taps, and the result is rescaled, saturated to 24 bits and emitted with a one-cycle valid strobe. Coefficients are runtime-writable, so the same block serves as a fixed band-stop or low-pass stage during bring-up.

---
 rtl/fir_seq_mac_if.sv | 30 +++
 rtl/fir_seq_mac.sv | 133 +++++++++++++
 tb/tb_fir_seq_mac.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_mac_if.sv
// rtl/fir_seq_mac_if.sv - sample, coefficient and status bundle for the sequential FIR MAC
interface fir_seq_mac_if #(
    parameter int N_TAPS = 16,
    parameter int DATA_W = 24,
    parameter int COEF_W = 16
);
    localparam int AW = $clog2(N_TAPS);

    logic signed [DATA_W-1:0] data_in;
    logic                     in_valid;
    logic                     coef_we;
    logic        [AW-1:0]     coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [DATA_W-1:0] data_out;
    logic                     out_valid;
    logic                     busy;
    logic                     overrun;

    // Source side: drives samples and coefficient writes, observes results
    modport master (
        output data_in, in_valid, coef_we, coef_addr, coef_data,
        input  data_out, out_valid, busy, overrun
    );

    // Filter side
    modport slave (
        input  data_in, in_valid, coef_we, coef_addr, coef_data,
        output data_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/fir_seq_mac.sv
// rtl/fir_seq_mac.sv - sequential single-MAC FIR with circular delay line and writable taps
module fir_seq_mac #(
    parameter int N_TAPS = 16,
    parameter int DATA_W = 24,
    parameter int COEF_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    fir_seq_mac_if.slave  bus
);
    localparam int AW     = $clog2(N_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + AW;

    // Largest positive Q1.(COEF_W-1) value: default h[0] gives near-unity pass-through
    localparam logic signed [COEF_W-1:0] COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic        [AW-1:0]     K_LAST   = AW'(N_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                   r_state;
    logic        [AW-1:0]     r_wr_ptr;
    logic        [AW-1:0]     r_newest;
    logic        [AW-1:0]     r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_line [N_TAPS];
    logic signed [COEF_W-1:0] r_coef [N_TAPS];
    logic signed [DATA_W-1:0] r_data_out;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_overrun;

    logic        [AW-1:0]     w_rd_ptr;
    logic signed [PROD_W-1:0] w_coef_ext;
    logic signed [PROD_W-1:0] w_samp_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [DATA_W-1:0] w_sat;

    // x[n-k] lives k slots behind the newest sample; the pointer wraps naturally
    assign w_rd_ptr   = r_newest - r_k;
    assign w_coef_ext = PROD_W'(r_coef[r_k]);
    assign w_samp_ext = PROD_W'(r_line[w_rd_ptr]);
    assign w_prod     = w_coef_ext * w_samp_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    // Drop the Q fraction (floor toward -inf) then clamp into the sample range
    assign w_shifted = r_acc >>> (COEF_W - 1);

    // Saturate the rescaled accumulator to DATA_W bits
    always_comb begin
        w_sat = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    // Control FSM, delay line, coefficient bank and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_newest    <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                r_line[i] <= '0;
                r_coef[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A write here lands before the first MAC read, so it applies to a
                    // sample accepted on this same edge
                    if (bus.coef_we) begin
                        r_coef[bus.coef_addr] <= bus.coef_data;
                    end
                    if (bus.in_valid) begin
                        r_line[r_wr_ptr] <= bus.data_in;
                        r_newest         <= r_wr_ptr;
                        r_wr_ptr         <= r_wr_ptr + AW'(1);
                        r_acc            <= '0;
                        r_k              <= '0;
                        r_busy           <= 1'b1;
                        r_state          <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (bus.in_valid) begin
                        r_overrun <= 1'b1;
                    end
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= r_k + AW'(1);
                    if (r_k == K_LAST) begin
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.in_valid) begin
                        r_overrun <= 1'b1;
                    end
                    r_data_out  <= w_sat;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_fir_seq_mac.sv
// tb/tb_fir_seq_mac.sv - directed self-checking bench for fir_seq_mac
module tb_fir_seq_mac;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fir_seq_mac_if #(.N_TAPS(16), .DATA_W(24), .COEF_W(16)) bus ();

    fir_seq_mac #(.N_TAPS(16), .DATA_W(24), .COEF_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input longint v);
        logic [63:0] t;
        t = v;
        @(negedge clk);
        bus.data_in  = t[23:0];
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wcoef(input int addr, input longint v);
        logic [63:0] t;
        logic [31:0] a;
        t = v;
        a = addr;
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a[3:0];
        bus.coef_data = t[15:0];
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_out(output longint d, output int lat, output int bcnt);
        int cnt;
        cnt  = 0;
        bcnt = 0;
        lat  = -1;
        d    = 0;
        while (cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (bus.out_valid) begin
                lat = cnt - 1;
                d   = longint'(bus.data_out);
                break;
            end
            if (bus.busy) bcnt++;
        end
        if (lat < 0) chk("out_valid_timeout", lat, 17);
    endtask

    initial begin
        longint d;
        int     lat;
        int     bcnt;
        int     nv;
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.data_in   = '0;
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", longint'(bus.data_out), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_overrun", longint'(bus.overrun), 0);
        reset = 1'b0;

        // Default coefficients: near-unity pass-through
        send(1000);
        wait_out(d, lat, bcnt);
        chk("def_pos_out", d, 999);
        chk("def_pos_latency", lat, 17);
        chk("def_pos_busy_cycles", bcnt, 17);
        @(negedge clk);
        chk("def_pulse_width", longint'(bus.out_valid), 0);
        chk("def_hold", longint'(bus.data_out), 999);
        send(-1000);
        wait_out(d, lat, bcnt);
        chk("def_neg_out", d, -1000);
        chk("def_neg_latency", lat, 17);
        chk("def_neg_busy_cycles", bcnt, 17);
        chk("def_overrun", longint'(bus.overrun), 0);

        // Impulse response with h[k] = k+1
        do_reset();
        for (int k = 0; k < 16; k++) wcoef(k, k + 1);
        send(32768);
        wait_out(d, lat, bcnt);
        chk("impulse[0]", d, 1);
        for (int i = 1; i <= 16; i++) begin
            send(0);
            wait_out(d, lat, bcnt);
            chk($sformatf("impulse[%0d]", i), d, (i < 16) ? i + 1 : 0);
        end

        // Saturation at both rails
        do_reset();
        for (int k = 0; k < 16; k++) wcoef(k, 32767);
        for (int i = 0; i < 16; i++) begin
            send(8388607);
            wait_out(d, lat, bcnt);
            if (i == 0) chk("sat_first_unclamped", d, 8388351);
            if (i == 15) chk("sat_pos", d, 8388607);
        end
        for (int i = 0; i < 16; i++) begin
            send(-8388608);
            wait_out(d, lat, bcnt);
            if (i == 15) chk("sat_neg", d, -8388608);
        end

        // Overrun: second sample 5 cycles into the MAC pass is dropped
        do_reset();
        chk("ovr_clear_after_reset", longint'(bus.overrun), 0);
        send(1000);
        repeat (4) @(posedge clk);
        #1;
        bus.data_in  = 24'd5000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(d, lat, bcnt);
        chk("ovr_inflight_out", d, 999);
        chk("ovr_set", longint'(bus.overrun), 1);
        wcoef(1, 32767);
        send(0);
        wait_out(d, lat, bcnt);
        chk("ovr_sample_dropped", d, 999);
        chk("ovr_sticky", longint'(bus.overrun), 1);

        // Coefficient write while busy is ignored, in IDLE it lands
        do_reset();
        send(1000);
        wcoef(0, 0);
        wait_out(d, lat, bcnt);
        chk("cwb_first", d, 999);
        send(1000);
        wait_out(d, lat, bcnt);
        chk("cwb_ignored", d, 999);
        wcoef(0, 0);
        send(1000);
        wait_out(d, lat, bcnt);
        chk("cw_idle_applied", d, 0);

        // Coefficient write together with the sample applies to that sample
        do_reset();
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 16'sd16384;
        bus.data_in   = 24'sd1000;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        wait_out(d, lat, bcnt);
        chk("cw_same_edge", d, 500);

        // Reset mid-MAC aborts the pass immediately
        do_reset();
        send(1000);
        wait_out(d, lat, bcnt);
        chk("rmid_pre", d, 999);
        send(1000);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_busy", longint'(bus.busy), 0);
        chk("rmid_data_out", longint'(bus.data_out), 0);
        chk("rmid_out_valid", longint'(bus.out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        chk("rmid_no_out_valid", nv, 0);
        send(1000);
        wait_out(d, lat, bcnt);
        chk("rmid_after_release", d, 999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
